conv_result_rx: RTL
===================

# conv_result_rx

Receiving end of the convolution output stream. Captures one 6x6 result frame: a 36-word burst of 16-bit fixed-point sums, framed by a high-level strobe. Rescales each word to an 8-bit pixel with round-half-up and saturation. Buffers the frame and drains it downstream over a valid/ready byte interface with row/column tags and end-of-frame marking.

## Interface
Parameters:
- WORDS, 36, words per frame; fixed 6x6 geometry.
- COLS, 6, words per output row; used for col/row tags.
- SHIFT, 7, right shift applied after rounding. The kernel gain is 128, so the shift restores pixel scale.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_in  in  1  frame strobe; high for each cycle carrying a valid word.
- din  in  16  result word, sampled on rising edges where st_in=1.
- pix_out  out  8  rescaled pixel.
- pix_valid  out  1  pix_out/pix_row/pix_col/pix_last valid.
- pix_ready  in  1  downstream accepts when pix_valid&pix_ready at an edge.
- pix_row  out  3  row index 0..5 of pix_out.
- pix_col  out  3  column index 0..5 of pix_out.
- pix_last  out  1  high with the 36th pixel (row 5, col 5).
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.
- short_err  out  1  one-cycle pulse when a frame aborts with fewer than WORDS words.
- overrun  out  1  sticky; set when st_in rises while not IDLE-armed. Cleared only by rst.
- busy  out  1  high in CAPTURE and DRAIN.

## Operation
- Buffer: 36 x 8-bit pixel RAM plus 6-bit write pointer wp and 6-bit read pointer rp.
- Conversion at capture: t = din + 64, computed 17 bits wide; p = t >> SHIFT. If p > 255, store 255; otherwise store p[7:0].
- States:
  - IDLE: waiting for a frame.
    - If st_in=1 and armed: store word 0, wp←1, go to CAPTURE.
  - CAPTURE: collecting words.
    - Each st_in=1 edge stores a word at wp and increments wp.
    - On storing word 35: wp←0 and go to DRAIN.
    - If st_in=0 while wp<36: pulse short_err, wp←0, discard the frame, return to IDLE.
  - DRAIN: emitting pixels.
    - pix_valid=1; pix_out=buf[rp]; pix_col=rp mod 6; pix_row=rp/6; pix_last=(rp==35).
    - Each handshake increments rp.
    - Handshake at rp=35: rp←0, pulse frame_done next cycle, go to IDLE.
- Arming: an armed flag is set whenever st_in=0 is sampled. A frame starts only on st_in=1 while armed, so each frame needs a low-to-high strobe transition.
  - Strobe cycles beyond word 35 (st_in still high) are ignored and do not set overrun.
- Overrun: st_in=1 sampled in DRAIN with armed=1 sets overrun. That burst is dropped entirely, and armed clears until st_in returns low.
- Word capture and handshake never occur in the same state, so there is no read/write collision.

## Timing
- Reset values: pix_out=0, pix_valid=0, pix_row=0, pix_col=0, pix_last=0, frame_done=0, short_err=0, overrun=0, busy=0. Internally: state=IDLE, wp=0, rp=0, armed=1.
- Reset mid-frame (any state) aborts at once: the buffer contents are don't-care and no pulses are emitted.
- Capture: one word per cycle, no backpressure on st_in/din; the block must accept 36 back-to-back words.
- Latency: pix_valid rises on the edge that stores word 35. The first pixel is presentable in the following cycle.
- Drain: one pixel per cycle at best when pix_ready is held high; pix_* held stable while pix_valid=1 and pix_ready=0.
- frame_done registered: high exactly one cycle, on the cycle after the last handshake; busy low from that same cycle.
- short_err registered: high for one cycle after the st_in=0 sample that aborted the frame.
- Minimum frame-to-frame gap: the last handshake, then an IDLE cycle, with st_in low at least one cycle before the next burst.

## Test plan
- Ramp frame: 36 back-to-back words din=k*128 (k=0..35), pix_ready=1 → pix_out=0..35 in order. Rows and columns step 0..5, pix_last on pixel 35, one frame_done pulse.
- Rounding/saturation: words 63, 64, 191, 32640, 32704, 0xFFFF → pixels 0, 1, 1, 255, 255, 255.
- Backpressure: toggle pix_ready 1/0 every cycle → 36 pixels all delivered once, values and tags stable during stalls, 72 cycles from first pix_valid to last handshake.
- Short frame: st_in high for 20 cycles then low → short_err pulse, busy low, no pix_valid. The next full frame is then received correctly.
- Overrun: new 36-word burst starts while DRAIN holds with pix_ready=0 → overrun=1 and stays 1. The first frame drains intact, and the second burst produces no pixels.
- Reset mid-DRAIN after 10 handshakes: all outputs return to reset values immediately. A subsequent full frame drains from pixel 0.

Source files
------------

// File: rtl/conv_result_rx.sv
// Captures a 6x6 frame of 16-bit convolution sums, rescales each to a saturated 8-bit pixel,
// then drains the frame over a valid/ready byte stream tagged with row/col/last.
module conv_result_rx #(
    parameter int WORDS = 36,
    parameter int COLS  = 6,
    parameter int SHIFT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_in,
    input  logic [15:0] din,
    output logic [7:0]  pix_out,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [2:0]  pix_row,
    output logic [2:0]  pix_col,
    output logic        pix_last,
    output logic        frame_done,
    output logic        short_err,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    localparam logic [5:0] LAST     = 6'(WORDS - 1);
    localparam logic [2:0] COL_LAST = 3'(COLS - 1);

    state_t      state;
    logic [5:0]  wp;
    logic [5:0]  rp;
    logic        armed;
    logic [7:0]  mem [WORDS];

    logic [16:0] rounded;
    logic [16:0] scaled;
    logic [7:0]  pix_w;
    logic        wr_en;
    logic [5:0]  rp_nxt;

    always_comb begin
        rounded = {1'b0, din} + 17'd64;
        scaled  = rounded >> SHIFT;
        pix_w   = (scaled > 17'd255) ? 8'hFF : scaled[7:0];
    end

    // wp is always 0 in IDLE, so the first word of a frame lands at address 0.
    assign wr_en  = st_in && ((state == IDLE && armed) || state == CAPTURE);
    assign rp_nxt = rp + 6'd1;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wp] <= pix_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wp         <= '0;
            rp         <= '0;
            armed      <= 1'b1;
            pix_out    <= '0;
            pix_valid  <= 1'b0;
            pix_row    <= '0;
            pix_col    <= '0;
            pix_last   <= 1'b0;
            frame_done <= 1'b0;
            short_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            short_err  <= 1'b0;
            if (!st_in)
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (st_in && armed) begin
                        wp    <= 6'd1;
                        armed <= 1'b0;
                        busy  <= 1'b1;
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (st_in) begin
                        if (wp == LAST) begin
                            // Word 0 is already in the buffer, so the first pixel can be presented now.
                            wp        <= '0;
                            rp        <= '0;
                            pix_out   <= mem[0];
                            pix_row   <= '0;
                            pix_col   <= '0;
                            pix_last  <= 1'b0;
                            pix_valid <= 1'b1;
                            state     <= DRAIN;
                        end else begin
                            wp <= wp + 6'd1;
                        end
                    end else begin
                        short_err <= 1'b1;
                        wp        <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                DRAIN: begin
                    if (st_in && armed) begin
                        overrun <= 1'b1;
                        armed   <= 1'b0;
                    end
                    if (pix_ready) begin
                        if (rp == LAST) begin
                            rp         <= '0;
                            pix_out    <= '0;
                            pix_row    <= '0;
                            pix_col    <= '0;
                            pix_last   <= 1'b0;
                            pix_valid  <= 1'b0;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            rp       <= rp_nxt;
                            pix_out  <= mem[rp_nxt];
                            pix_last <= (rp_nxt == LAST);
                            if (pix_col == COL_LAST) begin
                                pix_col <= '0;
                                pix_row <= pix_row + 3'd1;
                            end else begin
                                pix_col <= pix_col + 3'd1;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
